// File: rtl/aes_enc_round_ctrl_pkg.sv
// Shared types, widths and GF(2^8)/S-box helpers for the iterative AES-128 encryption engine.
package aes_enc_round_ctrl_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned BLK_W     = 128;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RIDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Forward S-box, entry 0x00 in the top byte so that index ~b selects S(b).
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[~b];
  endfunction

  function automatic logic [WORD_W-1:0] sbox_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_enc_round_ctrl_key_step.sv
// One step of AES-128 on-the-fly key expansion: next round key from current key and rcon.
module aes_enc_round_ctrl_key_step
  import aes_enc_round_ctrl_pkg::*;
(
  input  logic [BLK_W-1:0] rk,
  input  logic [7:0]       rcon,
  output logic [BLK_W-1:0] rk_next_c
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] t;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  // RotWord/SubWord/rcon on the last word, then the running XOR chain across the four words.
  always_comb begin
    {w0, w1, w2, w3} = rk;
    t         = sbox_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    n0        = w0 ^ t;
    n1        = w1 ^ n0;
    n2        = w2 ^ n1;
    n3        = w3 ^ n2;
    rk_next_c = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption engine: one cipher round per clock with on-the-fly key expansion.
module aes_enc_round_ctrl
  import aes_enc_round_ctrl_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  input  logic [BLK_W-1:0]  in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              busy,
  output logic [RIDX_W-1:0] round_idx
);

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [BLK_W-1:0]    rk_q, rk_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [RIDX_W-1:0]   ridx_q, ridx_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [BLK_W-1:0]    rk_next_c;
  logic [BLK_W-1:0]    sub_b_c, shift_r_c, mix_c_c, round_out_c;

  aes_enc_round_ctrl_key_step u_key_step (
    .rk        (rk_q),
    .rcon      (rcon_q),
    .rk_next_c (rk_next_c)
  );

  // Round datapath: SubBytes -> ShiftRows -> MixColumns (bypassed in the last round) -> AddRoundKey.
  always_comb begin : round_dp
    logic [7:0] a0, a1, a2, a3;
    sub_b_c   = '0;
    shift_r_c = '0;
    mix_c_c   = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int i = 0; i < 16; i++) begin
      sub_b_c[8*i +: 8] = sbox(blk_q[8*i +: 8]);
    end
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_r_c[127-8*(4*c+r) -: 8] = sub_b_c[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = shift_r_c[127-32*c -: 8];
      a1 = shift_r_c[119-32*c -: 8];
      a2 = shift_r_c[111-32*c -: 8];
      a3 = shift_r_c[103-32*c -: 8];
      mix_c_c[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mix_c_c[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mix_c_c[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mix_c_c[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    round_out_c = (state_q == ST_LAST) ? (shift_r_c ^ rk_next_c) : (mix_c_c ^ rk_next_c);
  end

  // Next-state and next-output logic for the IDLE/RUN/LAST/DONE sequence.
  always_comb begin : fsm_next
    state_d = state_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    ridx_d  = ridx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_RUN;
          blk_d   = in_data ^ in_key;
          rk_d    = in_key;
          rcon_d  = 8'h01;
          ridx_d  = RIDX_W'(1);
        end
      end
      ST_RUN: begin
        blk_d  = round_out_c;
        rk_d   = rk_next_c;
        rcon_d = xtime(rcon_q);
        ridx_d = ridx_q + RIDX_W'(1);
        if (ridx_q == RIDX_W'(NR - 1)) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        blk_d   = round_out_c;
        rk_d    = rk_next_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          ridx_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ridx_d  = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; synchronous reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      rk_q        <= '0;
      rcon_q      <= '0;
      ridx_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rk_q        <= rk_d;
      rcon_q      <= rcon_d;
      ridx_q      <= ridx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = blk_q;
  assign busy      = busy_q;
  assign round_idx = ridx_q;

endmodule
